// File: rtl/mod_reduce_param.sv
// mod_reduce_param
//   Bit-serial restoring divider: Z = X mod Y, Q = X div Y for an XW-bit
//   dividend and a YW-bit modulus, one dividend bit per clock.
//
// Parameters
//   XW  dividend / quotient width (>= 2)
//   YW  modulus / remainder width (>= 1, YW <= XW)
//   CW  bit-counter width, 2**CW > XW
//
// Ports
//   iClk        clock, rising edge
//   iRstn       synchronous active-low reset
//   iStart      start request, taken only while oReady=1
//   iX, iY      operands, sampled on the accepting edge only
//   oReady      1 in IDLE
//   oBusy       1 in RUN
//   oDataValid  one-cycle pulse, oZ/oQ/oErr valid
//   oErr        divide-by-zero flag, qualified by oDataValid
//   oZ, oQ      remainder / quotient, held until the next result
//   oState      current FSM state (IDLE=0, RUN=1, DONE=2) for observation
//
// Handshake: an operation is accepted on any rising edge where oReady=1 and
// iStart=1. There is no backpressure on the result: oDataValid is high for
// exactly one cycle and the consumer must take oZ/oQ/oErr then (they also
// stay stable afterwards). iStart while oReady=0 is dropped, not queued.
module mod_reduce_param #(
  parameter int XW = 2048,
  parameter int YW = 1024,
  parameter int CW = 12
) (
  input  logic          iClk,
  input  logic          iRstn,
  input  logic          iStart,
  input  logic [XW-1:0] iX,
  input  logic [YW-1:0] iY,
  output logic          oReady,
  output logic          oBusy,
  output logic          oDataValid,
  output logic          oErr,
  output logic [YW-1:0] oZ,
  output logic [XW-1:0] oQ,
  output logic [1:0]    oState
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [XW-1:0] xs;      // dividend shift register, MSB consumed first
  logic [YW-1:0] yr;      // latched modulus
  // Partial remainder. R < YR always holds, so its top bit would always be
  // zero; only the low YW bits are stored.
  logic [YW-1:0] r;
  logic [XW-1:0] q;
  logic [CW-1:0] cnt;

  logic [YW-1:0] z_reg;
  logic [XW-1:0] q_reg;
  logic          err_reg;

  logic [YW:0]   t;
  logic          ge;
  logic [YW-1:0] r_step;
  logic [XW-1:0] q_step;
  logic          accept;

  // ---------------- FSM ----------------
  always_ff @(posedge iClk) begin
    if (!iRstn) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    oReady     = 1'b0;
    oBusy      = 1'b0;
    oDataValid = 1'b0;
    case (state)
      S_IDLE: begin
        oReady = 1'b1;
        if (iStart) state_nxt = (iY == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        oBusy = 1'b1;
        if (cnt == '0) state_nxt = S_DONE;
      end
      S_DONE: begin
        oDataValid = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign oState = state;
  assign accept = (state == S_IDLE) && iStart;

  // ---------------- one restoring step ----------------
  // T is at most 2*YR-1, so YW+1 bits suffice; after the conditional
  // subtract the result is below YR and fits back into YW bits.
  always_comb begin
    t      = {r, xs[XW-1]};
    ge     = (t >= {1'b0, yr});
    r_step = ge ? YW'(t - {1'b0, yr}) : t[YW-1:0];
    q_step = {q[XW-2:0], ge};
  end

  // ---------------- datapath ----------------
  always_ff @(posedge iClk) begin
    if (!iRstn) begin
      xs      <= '0;
      yr      <= '0;
      r       <= '0;
      q       <= '0;
      cnt     <= '0;
      z_reg   <= '0;
      q_reg   <= '0;
      err_reg <= 1'b0;
    end else if (accept) begin
      xs  <= iX;
      yr  <= iY;
      r   <= '0;
      q   <= '0;
      cnt <= CW'(XW - 1);
      // Zero modulus skips RUN; results are loaded now for the DONE cycle.
      if (iY == '0) begin
        z_reg   <= '0;
        q_reg   <= '0;
        err_reg <= 1'b1;
      end
    end else if (state == S_RUN) begin
      xs  <= xs << 1;
      r   <= r_step;
      q   <= q_step;
      cnt <= cnt - CW'(1);
      // Last step: capture the final values on the edge entering DONE.
      if (cnt == '0) begin
        z_reg   <= r_step;
        q_reg   <= q_step;
        err_reg <= 1'b0;
      end
    end
  end

  assign oZ   = z_reg;
  assign oQ   = q_reg;
  assign oErr = err_reg;

endmodule
